// File: rtl/memory_controller.sv
// Load/store controller: samples LDR/STR in IDLE, runs one ACCESS cycle against a
// 256x32 word memory, then one DONE cycle that strobes LDRSel for loads.
module memory_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Opcode,
  input  logic [31:0] Address,
  input  logic [31:0] Data,
  output logic        LDRSel,
  output logic        AddressBusSel,
  output logic        RW,
  output logic [31:0] LDRDataToDestReg,
  output logic [31:0] AddressBus,
  output logic [31:0] DataBus,
  output logic        Busy,
  output logic [1:0]  state_dbg
);

  // Handshake: there is no ready/valid pair; the CPU presents an opcode and must
  // treat Busy=1 as "not accepted". Opcodes are sampled only on an edge in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  state_t      state, state_next;
  logic        is_ldr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] mem [256];
  logic [7:0]  idx;
  logic        start;

  assign idx       = addr_q[9:2];
  assign start     = (Opcode == OP_LDR) || (Opcode == OP_STR);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    AddressBusSel = 1'b0;
    RW            = 1'b1;
    AddressBus    = 32'd0;
    DataBus       = 32'd0;
    LDRSel        = 1'b0;
    Busy          = 1'b0;
    case (state)
      ACCESS: begin
        AddressBusSel = 1'b1;
        RW            = is_ldr_q;
        AddressBus    = addr_q;
        DataBus       = is_ldr_q ? mem[idx] : data_q;
        Busy          = 1'b1;
      end
      DONE: begin
        LDRSel = is_ldr_q;
        Busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction latch and load result; reset clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_ldr_q         <= 1'b0;
      addr_q           <= 32'd0;
      data_q           <= 32'd0;
      LDRDataToDestReg <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        is_ldr_q <= (Opcode == OP_LDR);
        addr_q   <= Address;
        data_q   <= Data;
      end
      if (state == ACCESS && is_ldr_q) LDRDataToDestReg <= mem[idx];
    end
  end

  // Memory is not reset; an async reset drops the FSM out of ACCESS first, aborting the write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && !is_ldr_q) mem[idx] <= data_q;
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed and random load/store sequences checked against a word-array model of memory.
module tb_memory_controller;
  localparam logic [3:0] LDR = 4'b1101;
  localparam logic [3:0] STR = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  Opcode = 4'd0;
  logic [31:0] Address = 32'd0;
  logic [31:0] Data = 32'd0;
  logic        LDRSel, AddressBusSel, RW, Busy;
  logic [31:0] LDRDataToDestReg, AddressBus, DataBus;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_mem [256];
  bit          exp_valid [256];
  logic [31:0] exp_ld;
  logic [31:0] exp_q[$];

  memory_controller dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Address(Address), .Data(Data),
    .LDRSel(LDRSel), .AddressBusSel(AddressBusSel), .RW(RW),
    .LDRDataToDestReg(LDRDataToDestReg), .AddressBus(AddressBus),
    .DataBus(DataBus), .Busy(Busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_ldrsel"}, {31'd0, LDRSel}, 32'd0);
    chk({tag, "_absel"}, {31'd0, AddressBusSel}, 32'd0);
    chk({tag, "_rw"}, {31'd0, RW}, 32'd1);
    chk({tag, "_abus"}, AddressBus, 32'd0);
    chk({tag, "_dbus"}, DataBus, 32'd0);
    chk({tag, "_ldr"}, LDRDataToDestReg, exp_ld);
  endtask

  // One full transaction; optionally flips Opcode to STR during ACCESS to test input masking.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input bit change_mid);
    bit       is_ld;
    int       idx;
    is_ld   = (op == LDR);
    idx     = int'(addr[9:2]);
    Opcode  = op;
    Address = addr;
    Data    = data;
    @(posedge clk); #1;
    chk("acc_busy", {31'd0, Busy}, 32'd1);
    chk("acc_absel", {31'd0, AddressBusSel}, 32'd1);
    chk("acc_abus", AddressBus, addr);
    chk("acc_rw", {31'd0, RW}, {31'd0, is_ld});
    chk("acc_dbus", DataBus, is_ld ? exp_mem[idx] : data);
    if (change_mid) begin
      Opcode  = STR;
      Address = $urandom;
      Data    = $urandom;
    end else begin
      Opcode = 4'd0;
    end
    if (is_ld) exp_ld = exp_mem[idx];
    else begin
      exp_mem[idx]   = data;
      exp_valid[idx] = 1'b1;
    end
    @(posedge clk); #1;
    Opcode = 4'd0;
    chk("done_busy", {31'd0, Busy}, 32'd1);
    chk("done_ldrsel", {31'd0, LDRSel}, {31'd0, is_ld});
    chk("done_absel", {31'd0, AddressBusSel}, 32'd0);
    chk("done_abus", AddressBus, 32'd0);
    chk("done_dbus", DataBus, 32'd0);
    chk("done_rw", {31'd0, RW}, 32'd1);
    chk("done_ldr", LDRDataToDestReg, exp_ld);
    @(posedge clk); #1;
    chk_idle("post");
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    int          k;
    exp_ld = 32'd0;
    for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;

    // Reset state
    #13;
    chk_idle("reset");
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_reset");

    // Directed STR then LDR to the same address
    run_txn(STR, 32'h12345678, 32'h9abcdef0, 1'b0);
    run_txn(LDR, 32'h12345678, 32'h0, 1'b0);
    chk("ldr_value", LDRDataToDestReg, 32'h9abcdef0);
    repeat (3) @(posedge clk);
    #1 chk("ldr_hold", LDRDataToDestReg, 32'h9abcdef0);

    // Aliasing: index 1 reached via different upper/lower address bits
    run_txn(STR, 32'h00000004, 32'h11111111, 1'b0);
    run_txn(LDR, 32'hFFFFFC07, 32'h0, 1'b0);
    chk("alias_value", LDRDataToDestReg, 32'h11111111);

    // NOP leaves the FSM in IDLE
    for (int i = 0; i < 4; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == LDR || op == STR);
      Opcode = op; Address = $urandom; Data = $urandom;
      @(posedge clk); #1;
      chk("nop_state", {30'd0, state_dbg}, 32'd0);
      chk_idle("nop");
    end
    Opcode = 4'd0;

    // Opcode flipped to STR during an LDR's ACCESS cycle
    run_txn(LDR, 32'h12345678, 32'h0, 1'b1);
    chk("midchange_ldr", LDRDataToDestReg, 32'h9abcdef0);
    run_txn(LDR, 32'h00000004, 32'h0, 1'b0);
    chk("midchange_mem", LDRDataToDestReg, 32'h11111111);

    // Reset in ACCESS of a STR aborts the write
    run_txn(STR, 32'h00000020, 32'h0badf00d, 1'b0);
    Opcode = STR; Address = 32'h00000020; Data = 32'hdeadbeef;
    @(posedge clk); #1;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd1);
    Opcode = 4'd0;
    rst_n  = 1'b0;
    exp_ld = 32'd0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(LDR, 32'h00000020, 32'h0, 1'b0);
    chk("rst_abort", LDRDataToDestReg, 32'h0badf00d);

    // Back-to-back: Opcode held at LDR while returning to IDLE starts a new transaction
    Opcode = LDR; Address = 32'h00000020;
    @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    chk("b2b_absel", {31'd0, AddressBusSel}, 32'd1);
    Opcode = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    chk_idle("b2b_end");

    // Random traffic over a small index pool; loads only hit written words
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 15);
      a = {$urandom_range(0, 32'h3fffff), 8'(k), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1 && exp_valid[k]) begin
        exp_q.push_back(exp_mem[k]);
        run_txn(LDR, a, $urandom, ($urandom_range(0, 3) == 0));
        chk("rand_ldr", LDRDataToDestReg, exp_q.pop_front());
      end else begin
        run_txn(STR, a, $urandom, ($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
